// File: rtl/memory_arbiter_pkg.sv
// Shared types for the cache-side memory arbiter: data words, FSM states and counter width.
package memory_arbiter_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2
    } arb_state_t;

    localparam int CNT_W     = 16;
    localparam int STARVE_W  = 4;

    typedef logic [CNT_W-1:0]    count_t;
    typedef logic [STARVE_W-1:0] starve_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// Cache pair + RAM bundle seen by the arbiter; slave is the arbiter, master drives caches and RAM.
interface memory_arbiter_if;
    import memory_arbiter_pkg::*;

    logic  iREN;
    word_t iaddr;
    logic  iwait;
    word_t iload;

    logic  dREN;
    logic  dWEN;
    word_t daddr;
    word_t dstore;
    logic  dwait;
    word_t dload;

    logic  ramREN;
    logic  ramWEN;
    word_t ramaddr;
    word_t ramstore;
    word_t ramload;
    logic  ramready;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/memory_arbiter.sv
// Single-ported RAM arbiter, dcache priority with icache starvation guard; grant registered (>=2 cycles).
// Requesters stall on iwait/dwait until the RAM pulses ramready; one IDLE turnaround between accesses.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              RST,
    memory_arbiter_if.slave   bus,
    output arb_state_t        state_o,
    output starve_t           starve_cnt_o,
    output count_t            icount_o,
    output count_t            dcount_o
);

    localparam starve_t STARVE_LIM = starve_t'(STARVE_MAX);

    arb_state_t state_q, state_d;
    starve_t    starve_q, starve_d;
    count_t     icount_q, dcount_q;

    logic  d_req, rdy, forced, i_done, d_done;
    logic  ram_ren, ram_wen;
    word_t ram_addr, ram_store, i_load, d_load;

    assign d_req  = bus.dREN | bus.dWEN;
    // A ready pulse arriving while reset is asserted must not complete anything.
    assign rdy    = bus.ramready & ~RST;
    assign forced = bus.iREN && (starve_q == STARVE_LIM);
    assign i_done = (state_q == IACC) && bus.iREN && rdy;
    assign d_done = (state_q == DACC) && d_req && rdy;

    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        ram_ren   = 1'b0;
        ram_wen   = 1'b0;
        ram_addr  = '0;
        ram_store = '0;
        i_load    = '0;
        d_load    = '0;

        unique case (state_q)
            IDLE: begin
                if (!bus.iREN)
                    starve_d = '0;
                if (d_req && !forced)
                    state_d = DACC;
                else if (bus.iREN)
                    state_d = IACC;
            end
            IACC: begin
                if (!bus.iREN) begin
                    state_d = IDLE;
                end else begin
                    ram_ren  = 1'b1;
                    ram_addr = bus.iaddr;
                    if (rdy) begin
                        i_load   = bus.ramload;
                        starve_d = '0;
                        state_d  = IDLE;
                    end
                end
            end
            DACC: begin
                if (!d_req) begin
                    state_d = IDLE;
                end else begin
                    ram_wen   = bus.dWEN;
                    ram_ren   = bus.dREN & ~bus.dWEN;
                    ram_addr  = bus.daddr;
                    ram_store = bus.dstore;
                    if (rdy) begin
                        d_load  = bus.dWEN ? '0 : bus.ramload;
                        state_d = IDLE;
                        if (bus.iREN && starve_q != STARVE_LIM)
                            starve_d = starve_q + starve_t'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            starve_q <= '0;
            icount_q <= '0;
            dcount_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            if (i_done)
                icount_q <= icount_q + count_t'(1);
            if (d_done)
                dcount_q <= dcount_q + count_t'(1);
        end
    end

    assign bus.iwait    = bus.iREN && !i_done;
    assign bus.dwait    = d_req && !d_done;
    assign bus.iload    = i_load;
    assign bus.dload    = d_load;
    assign bus.ramREN   = ram_ren;
    assign bus.ramWEN   = ram_wen;
    assign bus.ramaddr  = ram_addr;
    assign bus.ramstore = ram_store;

    assign state_o      = state_q;
    assign starve_cnt_o = starve_q;
    assign icount_o     = icount_q;
    assign dcount_o     = dcount_q;

endmodule
